// File: rtl/pixel_gray_track_if.sv
// Pixel stream bundle for pixel_gray_track: input pixel, control knobs,
// output pixel and darkest-pixel report. The master side drives the input
// pixel and control, and the slave side (the tracker) drives the results.
interface pixel_gray_track_if #(
    parameter int DW = 10,
    parameter int CW = 13
);
    logic          iDVAL;
    logic [DW-1:0] iRed;
    logic [DW-1:0] iGreen;
    logic [DW-1:0] iBlue;
    logic [CW-1:0] iH_Cont;
    logic [CW-1:0] iV_Cont;
    logic          iFrameStart;
    logic [1:0]    iMode;
    logic [DW-1:0] iThresh;
    logic [CW-1:0] iMarkX;
    logic [CW-1:0] iMarkY;

    logic          oDVAL;
    logic [DW-1:0] oDATA_R;
    logic [DW-1:0] oDATA_G;
    logic [DW-1:0] oDATA_B;
    logic [CW-1:0] oMinX;
    logic [CW-1:0] oMinY;
    logic [DW-1:0] oMinVal;
    logic          oMinValid;

    modport master (
        output iDVAL, iRed, iGreen, iBlue, iH_Cont, iV_Cont, iFrameStart,
               iMode, iThresh, iMarkX, iMarkY,
        input  oDVAL, oDATA_R, oDATA_G, oDATA_B, oMinX, oMinY, oMinVal, oMinValid
    );

    modport slave (
        input  iDVAL, iRed, iGreen, iBlue, iH_Cont, iV_Cont, iFrameStart,
               iMode, iThresh, iMarkX, iMarkY,
        output oDVAL, oDATA_R, oDATA_G, oDATA_B, oMinX, oMinY, oMinVal, oMinValid
    );
endinterface

// File: rtl/pixel_gray_track.sv
// Two-stage pixel pipeline: stage 1 computes a luma grey value and captures
// the pixel together with the control knobs that were present when that pixel
// was sampled. Stage 2 selects pass, grey, binary or track output, blanks a
// square marker, and tracks the darkest valid pixel of each frame.
module pixel_gray_track #(
    parameter int DW        = 10,
    parameter int CW        = 13,
    parameter int MARK_HALF = 20
) (
    input  logic              iCLK,
    input  logic              iRST,
    pixel_gray_track_if.slave bus
);

    localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
    localparam logic [DW-1:0] ALL_ZERO = {DW{1'b0}};
    localparam logic [CW-1:0] COORD_ZERO = {CW{1'b0}};
    localparam logic [7:0] K_R = 8'd77;
    localparam logic [7:0] K_G = 8'd150;
    localparam logic [7:0] K_B = 8'd29;
    localparam logic signed [CW:0] HALF_POS = (CW+1)'(MARK_HALF);
    localparam logic signed [CW:0] HALF_NEG = -HALF_POS;

    // Stage 1 registers
    logic          dval1_r;
    logic [DW-1:0] red1_r, green1_r, blue1_r, gray1_r;
    logic [CW-1:0] h1_r, v1_r;
    logic          fs1_r;
    logic [1:0]    mode1_r;
    logic [DW-1:0] thresh1_r;
    logic [CW-1:0] markX1_r, markY1_r;

    // Stage 2 (output) registers
    logic          oDVAL_r;
    logic [DW-1:0] oDataR_r, oDataG_r, oDataB_r;
    logic [DW-1:0] oMinVal_r;
    logic [CW-1:0] oMinX_r, oMinY_r;
    logic          oMinValid_r;

    // Running minimum of the frame in progress
    logic [DW-1:0] accVal_r;
    logic [CW-1:0] accX_r, accY_r;

    // Combinational helpers
    logic [DW+7:0] graySum_s;
    logic [DW-1:0] gray_s;
    logic [CW-1:0] cx_s, cy_s;
    logic signed [CW:0] dx_s, dy_s;
    logic          inMark_s;
    logic [DW-1:0] binVal_s;
    logic [DW-1:0] muxR_s, muxG_s, muxB_s;
    logic [DW-1:0] dataR_s, dataG_s, dataB_s;
    logic [DW-1:0] baseVal_s, nextVal_s;
    logic [CW-1:0] baseX_s, baseY_s, nextX_s, nextY_s;

    // Full-precision weighted luma; the weights sum to 256 so all-ones stays all-ones
    always_comb begin
        graySum_s = ({8'd0, bus.iRed}   * {{DW{1'b0}}, K_R})
                  + ({8'd0, bus.iGreen} * {{DW{1'b0}}, K_G})
                  + ({8'd0, bus.iBlue}  * {{DW{1'b0}}, K_B});
        gray_s    = graySum_s[DW+7:8];
    end

    // Stage 1: capture pixel, grey value and the control knobs sampled with it
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dval1_r   <= 1'b0;
            red1_r    <= ALL_ZERO;
            green1_r  <= ALL_ZERO;
            blue1_r   <= ALL_ZERO;
            gray1_r   <= ALL_ZERO;
            h1_r      <= COORD_ZERO;
            v1_r      <= COORD_ZERO;
            fs1_r     <= 1'b0;
            mode1_r   <= 2'd0;
            thresh1_r <= ALL_ZERO;
            markX1_r  <= COORD_ZERO;
            markY1_r  <= COORD_ZERO;
        end else begin
            dval1_r   <= bus.iDVAL;
            red1_r    <= bus.iRed;
            green1_r  <= bus.iGreen;
            blue1_r   <= bus.iBlue;
            gray1_r   <= gray_s;
            h1_r      <= bus.iH_Cont;
            v1_r      <= bus.iV_Cont;
            fs1_r     <= bus.iFrameStart;
            mode1_r   <= bus.iMode;
            thresh1_r <= bus.iThresh;
            markX1_r  <= bus.iMarkX;
            markY1_r  <= bus.iMarkY;
        end
    end

    // Marker hit test: signed distances so positions near zero never wrap
    always_comb begin
        if (mode1_r == 2'd3) begin
            cx_s = oMinX_r;
            cy_s = oMinY_r;
        end else begin
            cx_s = markX1_r;
            cy_s = markY1_r;
        end
        dx_s     = $signed({1'b0, h1_r}) - $signed({1'b0, cx_s});
        dy_s     = $signed({1'b0, v1_r}) - $signed({1'b0, cy_s});
        inMark_s = (dx_s < HALF_POS) && (dx_s > HALF_NEG) &&
                   (dy_s < HALF_POS) && (dy_s > HALF_NEG);
    end

    // Output mode select followed by marker blanking (pass mode never blanks)
    always_comb begin
        if (gray1_r < thresh1_r) begin
            binVal_s = ALL_ZERO;
        end else begin
            binVal_s = ALL_ONES;
        end
        case (mode1_r)
            2'd0: begin
                muxR_s = red1_r;
                muxG_s = green1_r;
                muxB_s = blue1_r;
            end
            2'd2: begin
                muxR_s = binVal_s;
                muxG_s = binVal_s;
                muxB_s = binVal_s;
            end
            default: begin
                muxR_s = gray1_r;
                muxG_s = gray1_r;
                muxB_s = gray1_r;
            end
        endcase
        if ((mode1_r != 2'd0) && inMark_s) begin
            dataR_s = ALL_ZERO;
            dataG_s = ALL_ZERO;
            dataB_s = ALL_ZERO;
        end else begin
            dataR_s = muxR_s;
            dataG_s = muxG_s;
            dataB_s = muxB_s;
        end
    end

    // Tracker next state: a frame start restarts the accumulator before the
    // coincident pixel is compared, so that pixel joins the new frame
    always_comb begin
        if (fs1_r) begin
            baseVal_s = ALL_ONES;
            baseX_s   = COORD_ZERO;
            baseY_s   = COORD_ZERO;
        end else begin
            baseVal_s = accVal_r;
            baseX_s   = accX_r;
            baseY_s   = accY_r;
        end
        if (dval1_r && (gray1_r < baseVal_s)) begin
            nextVal_s = gray1_r;
            nextX_s   = h1_r;
            nextY_s   = v1_r;
        end else begin
            nextVal_s = baseVal_s;
            nextX_s   = baseX_s;
            nextY_s   = baseY_s;
        end
    end

    // Stage 2: register output pixel
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDVAL_r  <= 1'b0;
            oDataR_r <= ALL_ZERO;
            oDataG_r <= ALL_ZERO;
            oDataB_r <= ALL_ZERO;
        end else begin
            oDVAL_r  <= dval1_r;
            oDataR_r <= dataR_s;
            oDataG_r <= dataG_s;
            oDataB_r <= dataB_s;
        end
    end

    // Tracker: accumulate frame minimum, publish it on each frame start
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            accVal_r    <= ALL_ONES;
            accX_r      <= COORD_ZERO;
            accY_r      <= COORD_ZERO;
            oMinVal_r   <= ALL_ONES;
            oMinX_r     <= COORD_ZERO;
            oMinY_r     <= COORD_ZERO;
            oMinValid_r <= 1'b0;
        end else begin
            accVal_r <= nextVal_s;
            accX_r   <= nextX_s;
            accY_r   <= nextY_s;
            if (fs1_r) begin
                oMinVal_r   <= accVal_r;
                oMinX_r     <= accX_r;
                oMinY_r     <= accY_r;
                oMinValid_r <= 1'b1;
            end else begin
                oMinValid_r <= 1'b0;
            end
        end
    end

    assign bus.oDVAL     = oDVAL_r;
    assign bus.oDATA_R   = oDataR_r;
    assign bus.oDATA_G   = oDataG_r;
    assign bus.oDATA_B   = oDataB_r;
    assign bus.oMinX     = oMinX_r;
    assign bus.oMinY     = oMinY_r;
    assign bus.oMinVal   = oMinVal_r;
    assign bus.oMinValid = oMinValid_r;

endmodule

// File: tb/tb_pixel_gray_track.sv
// Bench for pixel_gray_track: directed table, tracker corner sequences and a
// randomized run, all checked against a frame-level reference model.
module tb_pixel_gray_track;

    localparam int DW   = 10;
    localparam int CW   = 13;
    localparam int MH   = 20;
    localparam int ONES = 1023;

    logic iCLK = 1'b0;
    logic iRST = 1'b0;

    always #5 iCLK = ~iCLK;

    pixel_gray_track_if #(.DW(DW), .CW(CW)) bus ();

    pixel_gray_track #(.DW(DW), .CW(CW), .MARK_HALF(MH)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    typedef struct {
        bit dval; int r; int g; int b; int h; int v; bit fs;
        int mode; int thresh; int mx; int my;
        bit dir; int er; int eg; int eb;
    } vec_t;

    typedef struct {
        bit dval; int r; int g; int b;
        bit mv; int mval; int mx; int my;
        bit dir; int dr; int dg; int db;
    } exp_t;

    exp_t expQ[$];
    int nVec = 0;
    int nBad = 0;

    // Reference model: current-frame minimum and last reported minimum
    int curMin, curX, curY, repMin, repX, repY;

    task automatic check(input string nm, input int act, input int expv);
        nVec++;
        if (act !== expv) begin
            nBad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic vec_t mkv(bit dval, int r, int g, int b, int h, int v, bit fs,
                                 int mode, int thresh, int mx, int my);
        vec_t t;
        t.dval = dval; t.r = r; t.g = g; t.b = b; t.h = h; t.v = v; t.fs = fs;
        t.mode = mode; t.thresh = thresh; t.mx = mx; t.my = my;
        t.dir = 1'b0; t.er = 0; t.eg = 0; t.eb = 0;
        return t;
    endfunction

    // Grey-level pixel in pass mode with the manual marker out of the way
    function automatic vec_t pix(bit dval, int val, int h, int v, bit fs);
        return mkv(dval, val, val, val, h, v, fs, 0, 0, 4000, 4000);
    endfunction

    function automatic vec_t dirv(vec_t t, int er, int eg, int eb);
        vec_t u;
        u = t; u.dir = 1'b1; u.er = er; u.eg = eg; u.eb = eb;
        return u;
    endfunction

    task automatic drive(input vec_t v);
        bus.iDVAL       = v.dval;
        bus.iRed        = 10'(v.r);
        bus.iGreen      = 10'(v.g);
        bus.iBlue       = 10'(v.b);
        bus.iH_Cont     = 13'(v.h);
        bus.iV_Cont     = 13'(v.v);
        bus.iFrameStart = v.fs;
        bus.iMode       = 2'(v.mode);
        bus.iThresh     = 10'(v.thresh);
        bus.iMarkX      = 13'(v.mx);
        bus.iMarkY      = 13'(v.my);
    endtask

    task automatic modelReset();
        curMin = ONES; curX = 0; curY = 0;
        repMin = ONES; repX = 0; repY = 0;
        expQ.delete();
    endtask

    // Apply one input cycle; compare the output belonging to the input two cycles back
    task automatic step(input vec_t v);
        exp_t e, o;
        int gray, cx, cy, dx, dy, d;
        bit mk;
        @(negedge iCLK);
        drive(v);
        gray = (77 * v.r + 150 * v.g + 29 * v.b) / 256;
        cx = (v.mode == 3) ? repX : v.mx;
        cy = (v.mode == 3) ? repY : v.my;
        dx = v.h - cx;
        dy = v.v - cy;
        mk = (dx < MH) && (dx > -MH) && (dy < MH) && (dy > -MH);
        if (v.mode == 0) begin
            e.r = v.r; e.g = v.g; e.b = v.b;
        end else begin
            if (v.mode == 2) d = (gray < v.thresh) ? 0 : ONES;
            else d = gray;
            if (mk) d = 0;
            e.r = d; e.g = d; e.b = d;
        end
        e.dval = v.dval;
        e.mv = v.fs;
        if (v.fs) begin
            repMin = curMin; repX = curX; repY = curY;
            curMin = ONES; curX = 0; curY = 0;
        end
        if (v.dval && gray < curMin) begin
            curMin = gray; curX = v.h; curY = v.v;
        end
        e.mval = repMin; e.mx = repX; e.my = repY;
        e.dir = v.dir; e.dr = v.er; e.dg = v.eg; e.db = v.eb;
        expQ.push_back(e);
        @(posedge iCLK);
        #1;
        if (expQ.size() == 2) begin
            o = expQ.pop_front();
            check("oDVAL",     int'(bus.oDVAL),     int'(o.dval));
            check("oDATA_R",   int'(bus.oDATA_R),   o.r);
            check("oDATA_G",   int'(bus.oDATA_G),   o.g);
            check("oDATA_B",   int'(bus.oDATA_B),   o.b);
            check("oMinValid", int'(bus.oMinValid), int'(o.mv));
            check("oMinVal",   int'(bus.oMinVal),   o.mval);
            check("oMinX",     int'(bus.oMinX),     o.mx);
            check("oMinY",     int'(bus.oMinY),     o.my);
            if (o.dir) begin
                check("table_R", int'(bus.oDATA_R), o.dr);
                check("table_G", int'(bus.oDATA_G), o.dg);
                check("table_B", int'(bus.oDATA_B), o.db);
            end
        end
    endtask

    task automatic doReset();
        @(negedge iCLK);
        iRST = 1'b0;
        drive(pix(1'b0, 0, 0, 0, 1'b0));
        repeat (2) @(posedge iCLK);
        #1;
        check("rst_oDVAL",     int'(bus.oDVAL),     0);
        check("rst_oDATA_R",   int'(bus.oDATA_R),   0);
        check("rst_oDATA_G",   int'(bus.oDATA_G),   0);
        check("rst_oDATA_B",   int'(bus.oDATA_B),   0);
        check("rst_oMinX",     int'(bus.oMinX),     0);
        check("rst_oMinY",     int'(bus.oMinY),     0);
        check("rst_oMinVal",   int'(bus.oMinVal),   ONES);
        check("rst_oMinValid", int'(bus.oMinValid), 0);
        @(negedge iCLK);
        iRST = 1'b1;
        modelReset();
    endtask

    task automatic checkReport(input string nm, input int val, input int x, input int y);
        check({nm, "_valid"}, int'(bus.oMinValid), 1);
        check({nm, "_val"},   int'(bus.oMinVal),   val);
        check({nm, "_x"},     int'(bus.oMinX),     x);
        check({nm, "_y"},     int'(bus.oMinY),     y);
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        // Directed vectors with hand-derived outputs: luma = (77R+150G+29B)>>8
        tbl[0] = dirv(mkv(1'b1, 1023, 1023, 1023, 0, 0, 1'b0, 1, 0, 4000, 4000), 1023, 1023, 1023);
        tbl[1] = dirv(mkv(1'b1, 1023, 0, 0, 0, 0, 1'b0, 1, 0, 4000, 4000), 307, 307, 307);
        tbl[2] = dirv(mkv(1'b1, 511, 511, 511, 0, 0, 1'b0, 2, 512, 4000, 4000), 0, 0, 0);
        tbl[3] = dirv(mkv(1'b1, 512, 512, 512, 0, 0, 1'b0, 2, 512, 4000, 4000), 1023, 1023, 1023);
        tbl[4] = dirv(mkv(1'b1, 600, 600, 600, 501, 420, 1'b0, 1, 0, 520, 420), 0, 0, 0);
        tbl[5] = dirv(mkv(1'b1, 600, 600, 600, 500, 420, 1'b0, 1, 0, 520, 420), 600, 600, 600);
        tbl[6] = dirv(mkv(1'b1, 5, 6, 7, 520, 420, 1'b0, 0, 0, 520, 420), 5, 6, 7);
        tbl[7] = dirv(mkv(1'b0, 0, 0, 0, 0, 0, 1'b0, 2, 0, 4000, 4000), 1023, 1023, 1023);
        tbl[8] = dirv(mkv(1'b1, 100, 100, 100, 10, 10, 1'b0, 3, 0, 4000, 4000), 0, 0, 0);
        tbl[9] = dirv(mkv(1'b1, 100, 100, 100, 30, 10, 1'b0, 3, 0, 10, 10), 100, 100, 100);

        modelReset();
        drive(pix(1'b0, 0, 0, 0, 1'b0));
        doReset();

        for (int i = 0; i < 10; i++) step(tbl[i]);

        // Darkest pixel with a tie: the earlier pixel wins
        step(pix(1'b0, 0, 0, 0, 1'b1));
        step(pix(1'b1, 300, 10, 5, 1'b0));
        step(pix(1'b1, 100, 40, 7, 1'b0));
        step(pix(1'b1, 100, 41, 7, 1'b0));
        step(pix(1'b0, 0, 0, 0, 1'b1));
        step(pix(1'b0, 0, 0, 0, 1'b0));
        checkReport("tie", 100, 40, 7);

        // Pixel coinciding with frame start belongs to the new frame
        step(pix(1'b1, 200, 1, 1, 1'b0));
        step(pix(1'b0, 0, 0, 0, 1'b1));
        step(pix(1'b1, 200, 1, 1, 1'b0));
        step(pix(1'b1, 50, 3, 4, 1'b1));
        step(pix(1'b0, 0, 0, 0, 1'b0));
        checkReport("fsPixOld", 200, 1, 1);
        step(pix(1'b1, 60, 5, 5, 1'b0));
        step(pix(1'b1, 50, 6, 6, 1'b0));
        step(pix(1'b0, 0, 0, 0, 1'b1));
        step(pix(1'b0, 0, 0, 0, 1'b0));
        checkReport("fsPixNew", 50, 3, 4);

        // Reset mid-frame discards the partial minimum
        step(pix(1'b1, 20, 9, 9, 1'b0));
        step(pix(1'b0, 0, 0, 0, 1'b0));
        step(pix(1'b0, 0, 0, 0, 1'b0));
        doReset();
        step(pix(1'b0, 0, 0, 0, 1'b1));
        step(pix(1'b0, 0, 0, 0, 1'b0));
        checkReport("midReset", ONES, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rv = mkv(($urandom % 4) != 0,
                     $urandom % 1024, $urandom % 1024, $urandom % 1024,
                     $urandom % 64, $urandom % 64, ($urandom % 40) == 0,
                     $urandom % 4, $urandom % 1024, $urandom % 64, $urandom % 64);
            if (($urandom % 16) == 0) begin
                rv.r = 1023; rv.g = 1023; rv.b = 1023;
            end
            step(rv);
        end
        step(pix(1'b0, 0, 0, 0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
